uart_tx_frame: RTL

Parametrised UART transmitter, the next generation of our fixed 11-bit serialiser. Adds configurable data width, baud divider, stop-bit count, optional parity and a valid/ready handshake with gap-free back-to-back frames. It sits between a byte/word producer (FIFO or CPU register) and the serial pin.

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx_frame_baud_cnt.sv | 30 +++
 rtl/uart_tx_frame.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types, legal parameter ranges and the frame-length helper
// for the uart_tx_frame transmitter. Parity support is selected with the
// UART_TX_PARITY_EN macro.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 16;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Clock cycles occupied by one complete frame, start bit through last stop bit
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int stop_bits, input bit parity_en);
    return (1 + data_w + (parity_en ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_frame_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps;
// tick marks the last cycle of each serial bit. clear restarts the period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  // Free-running modulo counter, forced back to zero while cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear || (count_reg == LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready handshake and
// gap-free back-to-back frames. Frame: start, DATA_W bits LSB first, optional
// parity bit (UART_TX_PARITY_EN), STOP_BITS stop bits.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              tx,
  output logic              tx_busy
);

  localparam int BW = $clog2(DATA_W);

  uart_tx_state_t    state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              tick;
  logic              accept;
  logic              last_stop;
  logic              baud_clear;
`ifdef UART_TX_PARITY_EN
  logic              parity_reg;
`endif

  // The final cycle of the last stop bit may already accept the next word,
  // so a continuous producer sees no idle cycle between frames.
  assign last_stop  = (state_reg == STOP) && (bit_cnt_reg == BW'(STOP_BITS - 1)) && tick;
  assign tx_ready   = (state_reg == IDLE) || last_stop;
  assign accept     = tx_valid && tx_ready;
  assign baud_clear = accept || (state_reg == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  // Frame sequencer: state, shift register, bit counter and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else if (accept) begin
      state_reg   <= START;
      shift_reg   <= tx_data;
      bit_cnt_reg <= '0;
      tx          <= 1'b0;
      tx_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= (^tx_data) ^ parity_odd;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
        START: begin
          if (tick) begin
            state_reg <= DATA;
            tx        <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_reg == BW'(DATA_W - 1)) begin
              bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
              state_reg   <= PARITY;
              tx          <= parity_reg;
`else
              state_reg   <= STOP;
              tx          <= 1'b1;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
              shift_reg   <= shift_reg >> 1;
              tx          <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_reg <= STOP;
            tx        <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_cnt_reg == BW'(STOP_BITS - 1)) begin
              state_reg   <= IDLE;
              bit_cnt_reg <= '0;
              tx          <= 1'b1;
              tx_busy     <= 1'b0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx        <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
